// File: rtl/dac_serial_rx.sv
// Serial DAC word receiver: 16-bit frames under sync_n, two channels with ldac_n transfer.
// Optional saturating error counter enabled by defining DAC_RX_ERR_CNT_EN.
`timescale 1ns/1ps
module dac_serial_rx (
    input  logic        clk,
    input  logic        RESET_N,
    input  logic        sclk,
    input  logic        din,
    input  logic        sync_n,
    input  logic        ldac_n,
    output logic [11:0] chA_input,
    output logic [11:0] chB_input,
    output logic [11:0] chA_dac,
    output logic [11:0] chB_dac,
    output logic [2:0]  ctrlA,
    output logic [2:0]  ctrlB,
    output logic        word_valid,
    output logic        word_chan,
    output logic        err_short,
    output logic        err_long,
    output logic        busy
`ifdef DAC_RX_ERR_CNT_EN
    ,
    output logic [7:0]  err_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_sclk_s;
    logic [2:0]  r_sync_s;
    logic [1:0]  r_din_s;
    logic [1:0]  r_ldac_s;
    logic [1:0]  r_fill;
    logic        r_armed;
    logic [15:0] r_shift;
    logic [4:0]  r_cnt;
    logic        r_done;
    logic        r_valid;
    logic        r_chan;
    logic        r_err_short;
    logic        r_err_long;
    logic        r_long_seen;
    logic [11:0] r_a_in;
    logic [11:0] r_b_in;
    logic [11:0] r_a_dac;
    logic [11:0] r_b_dac;
    logic [2:0]  r_ctrl_a;
    logic [2:0]  r_ctrl_b;
    logic        w_busy;

    logic w_sclk_fall;
    logic w_sync_fall;
    logic w_sync_rise;
    logic w_accept;
    logic w_short;
    logic w_long;

    assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
    assign w_sync_fall = ~r_sync_s[1] & r_sync_s[2];
    assign w_sync_rise = r_sync_s[1] & ~r_sync_s[2];
    assign w_accept    = (r_state == SHIFT) & w_sclk_fall & (r_cnt == 5'd15);
    assign w_short     = (r_state == SHIFT) & w_sync_rise & ~w_accept;
    assign w_long      = (r_state == HOLD) & w_sclk_fall & ~r_sync_s[1] & ~r_long_seen;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_sclk_s <= 3'b000;
            r_sync_s <= 3'b111;
            r_din_s  <= 2'b00;
            r_ldac_s <= 2'b11;
            r_fill   <= 2'b00;
            r_armed  <= 1'b0;
        end else begin
            r_sclk_s <= {r_sclk_s[1:0], sclk};
            r_sync_s <= {r_sync_s[1:0], sync_n};
            r_din_s  <= {r_din_s[0], din};
            r_ldac_s <= {r_ldac_s[0], ldac_n};
            r_fill   <= {r_fill[0], 1'b1};
            // a frame may only open once sync_n has truly been seen high
            r_armed  <= r_armed | (r_fill[1] & r_sync_s[1]);
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) r_state <= IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (w_sync_fall & r_armed) w_next = SHIFT;
            SHIFT: begin
                if (w_accept)         w_next = w_sync_rise ? IDLE : HOLD;
                else if (w_sync_rise) w_next = IDLE;
            end
            HOLD:    if (w_sync_rise) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state != IDLE);
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            r_shift     <= '0;
            r_cnt       <= '0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            r_chan      <= 1'b0;
            r_err_short <= 1'b0;
            r_err_long  <= 1'b0;
            r_long_seen <= 1'b0;
            r_a_in      <= '0;
            r_b_in      <= '0;
            r_a_dac     <= '0;
            r_b_dac     <= '0;
            r_ctrl_a    <= '0;
            r_ctrl_b    <= '0;
        end else begin
            r_done      <= w_accept;
            r_valid     <= r_done;
            r_err_short <= w_short;
            r_err_long  <= w_long;
            if (r_state == IDLE && w_next == SHIFT) begin
                r_cnt       <= '0;
                r_long_seen <= 1'b0;
            end else if (r_state == SHIFT && w_sclk_fall) begin
                r_shift <= {r_shift[14:0], r_din_s[1]};
                r_cnt   <= r_cnt + 5'd1;
            end
            if (w_long) r_long_seen <= 1'b1;
            if (r_done) begin
                r_chan <= r_shift[15];
                if (r_shift[15]) begin
                    r_b_in   <= r_shift[11:0];
                    r_ctrl_b <= r_shift[14:12];
                end else begin
                    r_a_in   <= r_shift[11:0];
                    r_ctrl_a <= r_shift[14:12];
                end
            end
            if (!r_ldac_s[1]) begin
                r_a_dac <= r_a_in;
                r_b_dac <= r_b_in;
            end
        end
    end

`ifdef DAC_RX_ERR_CNT_EN
    logic [7:0] r_err_cnt;

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N)
            r_err_cnt <= '0;
        else if ((r_err_short | r_err_long) && r_err_cnt != 8'hFF)
            r_err_cnt <= r_err_cnt + 8'd1;
    end

    assign err_cnt = r_err_cnt;
`endif

    assign chA_input  = r_a_in;
    assign chB_input  = r_b_in;
    assign chA_dac    = r_a_dac;
    assign chB_dac    = r_b_dac;
    assign ctrlA      = r_ctrl_a;
    assign ctrlB      = r_ctrl_b;
    assign word_valid = r_valid;
    assign word_chan  = r_chan;
    assign err_short  = r_err_short;
    assign err_long   = r_err_long;
    assign busy       = w_busy;

endmodule

// File: doc/dac_serial_rx.md
DAC_SERIAL_RX -- requirements
Module: dac_serial_rx

Interface
REQ-001 The block SHALL have these ports, one per line, as name  direction  width  meaning:
  clk  input  1  system clock; at least 4x the SCLK frequency.
  RESET_N  input  1  reset, asynchronous, active-low.
  sclk  input  1  serial clock from the DAC driver; asynchronous to clk.
  din  input  1  serial data; sampled on sclk falling edge.
  sync_n  input  1  frame enable, active-low.
  ldac_n  input  1  load DAC, active-low.
  chA_input, chB_input  output  12  input registers.
  chA_dac, chB_dac  output  12  DAC registers.
  ctrlA, ctrlB  output  3  control bits [14:12] of the last word for each channel.
  word_valid  output  1  1-cycle pulse when a word is accepted.
  word_chan  output  1  channel of the last accepted word; 0=A, 1=B.
  err_short  output  1  1-cycle pulse; frame ended with fewer than 16 bits.
  err_long  output  1  1-cycle pulse; more than 16 falling edges in one frame.
  busy  output  1  high while state is not IDLE.
  err_cnt  output  8  error count; present only with DAC_RX_ERR_CNT_EN.

Function
REQ-002 sclk, din, sync_n and ldac_n SHALL each pass through a 2-flop synchronizer; edges SHALL be detected between sync stage 2 and a third delay flop.
REQ-003 The state machine SHALL have states IDLE, SHIFT and HOLD.
REQ-004 IDLE->SHIFT SHALL occur on a synchronized sync_n falling edge; the bit counter SHALL clear to 0 at that transition.
REQ-005 In SHIFT, each sclk falling edge SHALL shift synchronized din into a 16-bit register, MSB first, and increment a 5-bit bit counter.
REQ-006 On the 16th falling edge the state SHALL go SHIFT->HOLD.
REQ-007 One cycle after the 16th edge, word_valid SHALL pulse.
  - word[15] SHALL select the channel: 0=A, 1=B.
  - word[11:0] SHALL load that channel's input register.
  - word[14:12] SHALL load that channel's ctrl.
  - word_chan SHALL take word[15].
REQ-008 A sclk falling edge in HOLD while sync_n is low SHALL pulse err_long once per frame; the stored word SHALL be unaffected.
REQ-009 HOLD->IDLE SHALL occur on sync_n rising.
REQ-010 SHIFT->IDLE on sync_n rising with bit count below 16 SHALL pulse err_short and write no register.
REQ-011 A sync_n rising edge and the 16th sclk falling edge detected in the same cycle SHALL accept the word; no err_short.
REQ-012 While synchronized ldac_n is low, each cycle SHALL copy both input registers to chA_dac/chB_dac (level-transparent).
REQ-013 A word accepted while ldac_n is low SHALL reach its DAC register one cycle after word_valid.
REQ-014 Latency from the 16th sclk falling edge at the pin to word_valid SHALL be 4 clk cycles: 2 sync, 1 edge detect, 1 register.
REQ-015 sclk edges in IDLE SHALL be ignored.
REQ-016 A second sync_n falling edge SHALL be honoured only from IDLE.

Reset
REQ-017 On RESET_N low, all of the following SHALL clear to 0 immediately, independent of clk:
  - state to IDLE;
  - synchronizers, shift register and counters;
  - all data registers and all pulse outputs; busy=0.
REQ-018 The sync_n synchronizer SHALL reset to 1 and the ldac_n synchronizer SHALL reset to 1, so release of reset creates no false edge.
REQ-019 Reset asserted mid-frame SHALL discard the partial word with no err_short; after release, the first accepted frame SHALL start at a new sync_n falling edge.

Configuration
REQ-020 With DAC_RX_ERR_CNT_EN defined, err_cnt SHALL increment on each err_short or err_long pulse, saturate at 0xFF and clear on reset.
REQ-021 Without DAC_RX_ERR_CNT_EN, the err_cnt port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-022 Verification SHALL cover these directed scenarios, each stimulus -> required response:
  - Frame 0x35A5 (ctrl 011, A), ldac_n high -> chA_input=0x5A5, ctrlA=3'b011, word_chan=0, chA_dac unchanged=0, one word_valid.
  - Frame 0xBC3F, then 2-cycle ldac_n low pulse -> chB_input=0xC3F, ctrlB=3'b011; after the pulse chB_dac=0xC3F and chA_dac=chA_input.
  - sync_n high after 9 bits -> err_short pulse, registers unchanged, state returns to IDLE; with the macro, err_cnt=1.
  - 18 falling edges in one frame with word 0x3123 -> chA_input=0x123, exactly one err_long pulse.
  - ldac_n held low and frame 0x3FFF -> chA_dac=0xFFF one cycle after word_valid.
  - RESET_N asserted after bit 8, then full frame 0xB001 -> no error pulse, chB_input=0x001; 300 injected errors -> err_cnt=0xFF.
